mux_253_scan: RTL and testbench

- Sequencer sitting directly upstream/downstream of a 74x253 dual 4:1 tri-state mux.
- Drives the mux's sel[1:0], noe1 and noe2, and samples y1/y2 after a programmable settle time.
- Assembles the eight mux inputs into one parallel byte: i1 into bits 3:0, i2 into bits 7:4.
- Used for front-panel/switch-bank scanning; a start/busy/valid handshake lets the consumer request one scan or run continuously.

---
 rtl/mux_253_scan_pkg.sv | 18 +
 rtl/mux_253_scan_if.sv | 26 ++
 rtl/mux_253_scan_timer.sv | 35 +++
 rtl/mux_253_scan.sv | 132 +++++++++++++
 tb/tb_mux_253_scan.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mux_253_scan_pkg.sv
// Shared types and constants for the 74x253 scan sequencer.
package mux_253_scan_pkg;

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Settle counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/mux_253_scan_if.sv
// Handshake and mux-side signals between the scanner and its neighbours.
interface mux_253_scan_if;
  import mux_253_scan_pkg::*;

  logic              start;
  logic              cont;
  logic [SEL_W-1:0]  sel;
  logic              noe1;
  logic              noe2;
  logic              y1;
  logic              y2;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              busy;

  modport master (
    input  start, cont, y1, y2,
    output sel, noe1, noe2, data, valid, busy
  );

  modport slave (
    output start, cont, y1, y2,
    input  sel, noe1, noe2, data, valid, busy
  );

endinterface

// File: rtl/mux_253_scan_timer.sv
// Loadable down-counter that stops at zero and flags it.
module mux_253_scan_timer #(
  parameter int unsigned CW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_c_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/mux_253_scan.sv
// Scan sequencer for a 74x253 dual 4:1 mux: steps sel, samples y1/y2 after
// SETTLE cycles and publishes {i2,i1} as one byte with a valid pulse.
module mux_253_scan
  import mux_253_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  mux_253_scan_if.master   bus
);

  localparam int unsigned   CW     = cnt_width(SETTLE);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

  if (SETTLE < 1) begin : g_settle_chk
    $error("mux_253_scan: SETTLE must be at least 1");
  end

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              noe_q, noe_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              tmr_load;
  logic              tmr_dec;
  logic              tmr_zero;

  mux_253_scan_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (RELOAD),
    .dec_i      (tmr_dec),
    .zero_c_o   (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    noe_d    = noe_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    shadow_d = shadow_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SETTLE;
          sel_d    = '0;
          noe_d    = 1'b0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (tmr_zero) begin
          // Lane k of mux 1 lands in bit k, lane k of mux 2 in bit 4+k.
          shadow_d[{1'b0, sel_q}] = bus.y1;
          shadow_d[{1'b1, sel_q}] = bus.y2;
          if (sel_q != 2'd3) begin
            sel_d    = SEL_W'(sel_q + 2'd1);
            tmr_load = 1'b1;
          end else begin
            state_d = ST_DONE;
            data_d  = shadow_d;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            noe_d   = 1'b1;
            sel_d   = '0;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_DONE: begin
        // The DONE cycle itself keeps the mux released between scans.
        if (bus.cont || bus.start) begin
          state_d  = ST_SETTLE;
          sel_d    = '0;
          noe_d    = 1'b0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        noe_d   = 1'b1;
        busy_d  = 1'b0;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      noe_q    <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      noe_q    <= noe_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.noe1  = noe_q;
  assign bus.noe2  = noe_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.data  = data_q;

endmodule

// File: tb/tb_mux_253_scan.sv
// Directed bench: three scanners (SETTLE=2,1,3) each driving a modelled 74x253.
module tb_mux_253_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] i1;
  logic [3:0] i2;
  int         n_pass = 0;
  int         n_chk  = 0;
  int         xhits  = 0;

  always #5 clk = ~clk;

  mux_253_scan_if bus_a ();
  mux_253_scan_if bus_b ();
  mux_253_scan_if bus_c ();

  mux_253_scan #(.SETTLE(2)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
  mux_253_scan #(.SETTLE(1)) u_b (.clk(clk), .reset(reset), .bus(bus_b));
  mux_253_scan #(.SETTLE(3)) u_c (.clk(clk), .reset(reset), .bus(bus_c));

  // 74x253 behaviour: selected input when enabled, undriven otherwise.
  assign bus_a.y1 = bus_a.noe1 ? 1'bx : i1[bus_a.sel];
  assign bus_a.y2 = bus_a.noe2 ? 1'bx : i2[bus_a.sel];
  assign bus_b.y1 = bus_b.noe1 ? 1'bx : i1[bus_b.sel];
  assign bus_b.y2 = bus_b.noe2 ? 1'bx : i2[bus_b.sel];
  assign bus_c.y1 = bus_c.noe1 ? 1'bx : i1[bus_c.sel];
  assign bus_c.y2 = bus_c.noe2 ? 1'bx : i2[bus_c.sel];

  // Unknown mux output while a scanner has the mux enabled would be sampled.
  always @(negedge clk) begin
    if (!bus_b.noe1 && $isunknown({bus_b.y1, bus_b.y2})) xhits++;
    if (!bus_c.noe1 && $isunknown({bus_c.y1, bus_c.y2})) xhits++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] st_a();
    return {2'b00, bus_a.noe1, bus_a.noe2, bus_a.sel, bus_a.busy, bus_a.valid, bus_a.data};
  endfunction

  function automatic logic [15:0] exp_st(input logic noe, input logic [1:0] sel,
                                         input logic busy, input logic valid,
                                         input logic [7:0] data);
    return {2'b00, noe, noe, sel, busy, valid, data};
  endfunction

  initial begin
    logic       got_b, got_c;
    int         nv;
    logic [7:0] ed;

    reset = 1'b1;
    i1 = 4'h0; i2 = 4'h0;
    bus_a.start = 1'b0; bus_a.cont = 1'b0;
    bus_b.start = 1'b0; bus_b.cont = 1'b0;
    bus_c.start = 1'b0; bus_c.cont = 1'b0;
    step(); step();
    reset = 1'b0;

    // Idle after reset
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle", st_a(), exp_st(1'b1, 2'd0, 1'b0, 1'b0, 8'h00));
    end

    // Single scan, SETTLE=2: k is the index of the edge just passed
    i1 = 4'b1010; i2 = 4'b0110;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) step();
      chk($sformatf("single_k%0d", k), st_a(),
          exp_st(!(k < 8), (k < 8) ? 2'(k / 2) : 2'd0, (k < 8), (k == 8),
                 (k >= 8) ? 8'h6A : 8'h00));
    end

    // Continuous mode: two scans, inputs swapped during the first DONE
    i1 = 4'h5; i2 = 4'hC;
    bus_a.cont = 1'b1; bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      logic inscan;
      logic [1:0] esel;
      if (k > 0) step();
      inscan = (k < 8) || (k >= 9 && k < 17);
      esel   = (k < 8) ? 2'(k / 2) : (k >= 9 && k < 17) ? 2'((k - 9) / 2) : 2'd0;
      ed     = (k < 8) ? 8'h6A : (k < 17) ? 8'hC5 : 8'h0F;
      chk($sformatf("cont_k%0d", k), st_a(), exp_st(!inscan, esel, inscan, (k == 8 || k == 17), ed));
      if (k == 8) begin
        i1 = 4'hF; i2 = 4'h0;
      end
      if (k == 9) bus_a.cont = 1'b0;
    end

    // Second start mid-scan is dropped
    step();
    i1 = 4'h3; i2 = 4'h9;
    bus_a.start = 1'b1;
    step();
    nv = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus_a.valid) nv++;
      if (k == 4) chk("restart_sel", 16'(bus_a.sel), 16'd2);
      bus_a.start = (k == 3);
      step();
    end
    bus_a.start = 1'b0;
    chk("restart_pulses", 16'(nv), 16'd1);
    chk("restart_data", 16'(bus_a.data), 16'h0093);

    // Reset mid-scan aborts and clears data
    i1 = 4'hF; i2 = 4'hF;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    reset = 1'b1;
    step();
    chk("abort", st_a(), exp_st(1'b1, 2'd0, 1'b0, 1'b0, 8'h00));
    reset = 1'b0;
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus_a.valid) nv++;
    end
    chk("abort_novalid", 16'(nv), 16'd0);

    // All 256 patterns on SETTLE=1 and SETTLE=3 with latency checks
    for (int p = 0; p < 256; p++) begin
      i1 = 4'(p);
      i2 = 4'(p >> 4);
      bus_b.start = 1'b1; bus_c.start = 1'b1;
      step();
      bus_b.start = 1'b0; bus_c.start = 1'b0;
      got_b = 1'b0; got_c = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (bus_b.valid && !got_b) begin
          chk($sformatf("exh_s1_p%0d", p), {8'(k), bus_b.data}, {8'd4, 8'(p)});
          got_b = 1'b1;
        end
        if (bus_c.valid && !got_c) begin
          chk($sformatf("exh_s3_p%0d", p), {8'(k), bus_c.data}, {8'd12, 8'(p)});
          got_c = 1'b1;
        end
        if (got_b && got_c) break;
        step();
      end
      chk($sformatf("exh_done_p%0d", p), {14'd0, got_b, got_c}, 16'h0003);
    end
    chk("exh_no_x", 16'(xhits), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
